// File: rtl/wb_write_port_arbiter.sv
// Write-back port arbiter: merges two write-back lanes onto one register-file
// write port, holding writes it cannot serve yet in an in-order pending queue.
module wb_write_port_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RegWriteEn_inst0_WB,
    input  logic [ADDR_W-1:0]          dest_reg_inst0_WB,
    input  logic [DATA_W-1:0]          writeData_inst0_WB,
    input  logic                       RegWriteEn_inst1_WB,
    input  logic [ADDR_W-1:0]          dest_reg_inst1_WB,
    input  logic [DATA_W-1:0]          writeData_inst1_WB,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data,
    output logic                       wb_stall,
    output logic [$clog2(DEPTH+1)-1:0] pend_count,
    output logic                       overflow_err
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              overflow_q;
    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane qualification: x0 writes vanish; a same-destination pair keeps only the younger lane.
    logic v0, v1;
    assign v1 = RegWriteEn_inst1_WB && (dest_reg_inst1_WB != '0);
    assign v0 = RegWriteEn_inst0_WB && (dest_reg_inst0_WB != '0)
                && !(v1 && (dest_reg_inst0_WB == dest_reg_inst1_WB));

    logic              pop;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              cand0_v, cand1_v;
    logic [ADDR_W-1:0] cand0_a, cand1_a;
    logic [DATA_W-1:0] cand0_d, cand1_d;

    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_addr  = rf_waddr_q;
        sel_data  = rf_wdata_q;
        cand0_v   = 1'b0;
        cand0_a   = dest_reg_inst0_WB;
        cand0_d   = writeData_inst0_WB;
        cand1_v   = 1'b0;
        cand1_a   = dest_reg_inst1_WB;
        cand1_d   = writeData_inst1_WB;
        if (count_q != '0) begin
            // Older queued writes go first; every new lane write queues behind them.
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_addr  = q_addr_q[rd_ptr_q];
            sel_data  = q_data_q[rd_ptr_q];
            if (v0) begin
                cand0_v = 1'b1;
                cand1_v = v1;
            end else if (v1) begin
                cand0_v = 1'b1;
                cand0_a = dest_reg_inst1_WB;
                cand0_d = writeData_inst1_WB;
            end
        end else if (v0) begin
            sel_valid = 1'b1;
            sel_addr  = dest_reg_inst0_WB;
            sel_data  = writeData_inst0_WB;
            cand0_v   = v1;
            cand0_a   = dest_reg_inst1_WB;
            cand0_d   = writeData_inst1_WB;
        end else if (v1) begin
            sel_valid = 1'b1;
            sel_addr  = dest_reg_inst1_WB;
            sel_data  = writeData_inst1_WB;
        end
    end

    // Free slots count the entry popped this cycle; pushes beyond that are dropped.
    logic [CNT_W:0]   free_slots;
    logic             push0, push1, ovf_now;
    logic [PTR_W-1:0] wr_slot0, wr_slot1;

    assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
    assign push0      = cand0_v && (free_slots >= (CNT_W+1)'(1));
    assign push1      = cand1_v && (free_slots >= (CNT_W+1)'(2));
    assign ovf_now    = (cand0_v && !push0) || (cand1_v && !push1);
    assign wr_slot0   = wr_ptr_q;
    assign wr_slot1   = ptr_inc(wr_ptr_q);

    always_comb begin
        count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push1) begin
            wr_ptr_d = ptr_inc(wr_slot1);
        end else if (push0) begin
            wr_ptr_d = wr_slot1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rf_we_q <= sel_valid;
            if (sel_valid) begin
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
            end
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (ovf_now) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset: only entries inside the occupancy window are ever read.
    always_ff @(posedge clk) begin
        if (push0) begin
            q_addr_q[wr_slot0] <= cand0_a;
            q_data_q[wr_slot0] <= cand0_d;
        end
        if (push1) begin
            q_addr_q[wr_slot1] <= cand1_a;
            q_data_q[wr_slot1] <= cand1_d;
        end
    end

    // Scan oldest to newest so the last match (newest write) wins.
    logic [PTR_W:0]   lk_sum;
    logic [PTR_W-1:0] lk_idx;

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_sum      = '0;
        lk_idx      = '0;
        if (lookup_addr != '0) begin
            if (rf_we_q && (rf_waddr_q == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = rf_wdata_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                lk_sum = {1'b0, rd_ptr_q} + (PTR_W+1)'(i);
                if (lk_sum >= (PTR_W+1)'(DEPTH)) begin
                    lk_sum = lk_sum - (PTR_W+1)'(DEPTH);
                end
                lk_idx = lk_sum[PTR_W-1:0];
                if ((i < int'(count_q)) && (q_addr_q[lk_idx] == lookup_addr)) begin
                    lookup_hit  = 1'b1;
                    lookup_data = q_data_q[lk_idx];
                end
            end
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign pend_count   = count_q;
    assign wb_stall     = (count_q >= CNT_W'(DEPTH-1));
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Bench for wb_write_port_arbiter: directed vector table, multi-cycle corner
// sequences, and random traffic against a queue-based reference model.
module tb_wb_write_port_arbiter;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWriteEn_inst0_WB, RegWriteEn_inst1_WB;
    logic [ADDR_W-1:0] dest_reg_inst0_WB, dest_reg_inst1_WB;
    logic [DATA_W-1:0] writeData_inst0_WB, writeData_inst1_WB;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic              wb_stall;
    logic [CNT_W-1:0]  pend_count;
    logic              overflow_err;

    wb_write_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .RegWriteEn_inst0_WB (RegWriteEn_inst0_WB),
        .dest_reg_inst0_WB   (dest_reg_inst0_WB),
        .writeData_inst0_WB  (writeData_inst0_WB),
        .RegWriteEn_inst1_WB (RegWriteEn_inst1_WB),
        .dest_reg_inst1_WB   (dest_reg_inst1_WB),
        .writeData_inst1_WB  (writeData_inst1_WB),
        .rf_we               (rf_we),
        .rf_waddr            (rf_waddr),
        .rf_wdata            (rf_wdata),
        .lookup_addr         (lookup_addr),
        .lookup_hit          (lookup_hit),
        .lookup_data         (lookup_data),
        .wb_stall            (wb_stall),
        .pend_count          (pend_count),
        .overflow_err        (overflow_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    // Reference model: pending writes in program order plus the visible output stage.
    wr_t               m_q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ovf;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    bit sb_on = 1'b0;

    typedef struct {
        logic              e0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              e1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic [ADDR_W-1:0] lk;
        logic              x_we;
        logic [ADDR_W-1:0] x_addr;
        logic [DATA_W-1:0] x_data;
        int                x_cnt;
        logic              x_hit;
        logic [DATA_W-1:0] x_ldata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                              input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        wr_t reqs[$];
        wr_t w;
        if (e0 && a0 != 0 && !(e1 && a1 != 0 && a1 == a0)) reqs.push_back('{a: a0, d: d0});
        if (e1 && a1 != 0) reqs.push_back('{a: a1, d: d1});
        if (m_q.size() > 0) begin
            w = m_q.pop_front();
            m_we = 1'b1; m_addr = w.a; m_data = w.d;
        end else if (reqs.size() > 0) begin
            w = reqs.pop_front();
            m_we = 1'b1; m_addr = w.a; m_data = w.d;
        end else begin
            m_we = 1'b0;
        end
        foreach (reqs[k]) begin
            if (m_q.size() < DEPTH) m_q.push_back(reqs[k]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_lookup(input logic [ADDR_W-1:0] addr, output logic hit, output logic [DATA_W-1:0] data);
        hit = 1'b0;
        data = '0;
        if (addr != 0) begin
            for (int k = m_q.size() - 1; k >= 0; k--) begin
                if (!hit && m_q[k].a == addr) begin
                    hit = 1'b1;
                    data = m_q[k].d;
                end
            end
            if (!hit && m_we && m_addr == addr) begin
                hit = 1'b1;
                data = m_data;
            end
        end
    endtask

    task automatic compare_all();
        logic              h;
        logic [DATA_W-1:0] d;
        logic [ADDR_W+DATA_W-1:0] e;
        model_lookup(lookup_addr, h, d);
        check("rf_we", rf_we, m_we);
        check("rf_waddr", rf_waddr, m_addr);
        check("rf_wdata", rf_wdata, m_data);
        check("pend_count", pend_count, m_q.size());
        check("wb_stall", wb_stall, (m_q.size() >= DEPTH - 1));
        check("overflow_err", overflow_err, m_ovf);
        check("lookup_hit", lookup_hit, h);
        check("lookup_data", lookup_data, d);
        if (sb_on && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_commit_order", {rf_waddr, rf_wdata}, e);
            end
        end
    endtask

    // Called at a negedge: drive lanes, clock once, update model, then probe lookup.
    task automatic run_cycle(input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                             input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                             input logic [ADDR_W-1:0] lk);
        RegWriteEn_inst0_WB = e0; dest_reg_inst0_WB = a0; writeData_inst0_WB = d0;
        RegWriteEn_inst1_WB = e1; dest_reg_inst1_WB = a1; writeData_inst1_WB = d1;
        @(posedge clk);
        model_step(e0, a0, d0, e1, a1, d1);
        #1;
        lookup_addr = lk;
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic [ADDR_W-1:0] lk);
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, lk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit stall_seen;

        vecs[0] = '{1, 5, 32'hAA, 0, 0, 0,        5, 1, 5, 32'hAA, 0, 1, 32'hAA};
        vecs[1] = '{1, 3, 32'h11, 1, 4, 32'h22,   4, 1, 3, 32'h11, 1, 1, 32'h22};
        vecs[2] = '{0, 0, 0,      0, 0, 0,        3, 1, 4, 32'h22, 0, 0, 0};
        vecs[3] = '{1, 7, 32'h01, 1, 7, 32'h02,   7, 1, 7, 32'h02, 0, 1, 32'h02};
        vecs[4] = '{0, 0, 0,      0, 0, 0,        7, 0, 7, 32'h02, 0, 0, 0};
        vecs[5] = '{1, 0, 32'h55, 1, 0, 32'h66,   0, 0, 7, 32'h02, 0, 0, 0};
        vecs[6] = '{1, 0, 32'h33, 1, 9, 32'h99,   0, 1, 9, 32'h99, 0, 0, 0};
        vecs[7] = '{0, 6, 32'h77, 0, 0, 0,        9, 0, 9, 32'h99, 0, 0, 0};

        // Clock/reset
        reset = 1'b1;
        RegWriteEn_inst0_WB = 0; dest_reg_inst0_WB = 0; writeData_inst0_WB = 0;
        RegWriteEn_inst1_WB = 0; dest_reg_inst1_WB = 0; writeData_inst1_WB = 0;
        lookup_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_waddr", rf_waddr, 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_pend_count", pend_count, 0);
        check("reset_overflow", overflow_err, 0);
        check("reset_wb_stall", wb_stall, 0);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_cycle(vecs[i].e0, vecs[i].a0, vecs[i].d0, vecs[i].e1, vecs[i].a1, vecs[i].d1, vecs[i].lk);
            check($sformatf("vec%0d_we", i), rf_we, vecs[i].x_we);
            check($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].x_addr);
            check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].x_data);
            check($sformatf("vec%0d_cnt", i), pend_count, vecs[i].x_cnt);
            check($sformatf("vec%0d_hit", i), lookup_hit, vecs[i].x_hit);
            check($sformatf("vec%0d_ldata", i), lookup_data, vecs[i].x_ldata);
        end

        // Back-to-back dual writes until the stall rises, then drain in program order
        sb_on = 1'b1;
        n = 0;
        stall_seen = 1'b0;
        while (!stall_seen && n < 6) begin
            exp_q.push_back({ADDR_W'(10 + 2*n), DATA_W'(32'h100 + 2*n)});
            exp_q.push_back({ADDR_W'(11 + 2*n), DATA_W'(32'h101 + 2*n)});
            run_cycle(1, ADDR_W'(10 + 2*n), DATA_W'(32'h100 + 2*n),
                      1, ADDR_W'(11 + 2*n), DATA_W'(32'h101 + 2*n), ADDR_W'(11 + 2*n));
            n++;
            if (wb_stall === 1'b1) begin
                stall_seen = 1'b1;
                check("stall_at_count", pend_count, DEPTH - 1);
            end
        end
        check("stall_seen", stall_seen, 1);
        check("stall_after_three", n, 3);
        n = 0;
        while ((pend_count !== 0 || rf_we !== 1'b0) && n < 12) begin
            idle_cycle(ADDR_W'($urandom_range(10, 15)));
            n++;
        end
        check("drain_done", pend_count, 0);
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_no_overflow", overflow_err, 0);
        sb_on = 1'b0;

        // Ignore the stall: five dual-write cycles overrun the queue
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, ADDR_W'(16 + 2*i), DATA_W'(32'h200 + i), 1, ADDR_W'(17 + 2*i), DATA_W'(32'h300 + i), 0);
        end
        check("ovf_set", overflow_err, 1);
        check("ovf_full_count", pend_count, DEPTH);
        idle_cycle(0);
        idle_cycle(0);
        check("ovf_sticky", overflow_err, 1);
        check("ovf_draining", pend_count, 2);

        // Asynchronous reset mid-drain
        #2;
        reset = 1'b1;
        #1;
        check("areset_rf_we", rf_we, 0);
        check("areset_pend_count", pend_count, 0);
        check("areset_overflow", overflow_err, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_cycle(0);

        // Random traffic honouring the stall
        for (int i = 0; i < 400; i++) begin
            logic e0, e1;
            e0 = ($urandom_range(0, 3) != 0);
            e1 = ($urandom_range(0, 3) != 0);
            if (m_q.size() >= DEPTH - 1) begin
                e0 = 1'b0;
                e1 = 1'b0;
            end
            run_cycle(e0, ADDR_W'($urandom_range(0, 7)), $urandom(),
                      e1, ADDR_W'($urandom_range(0, 7)), $urandom(),
                      ADDR_W'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_port_arbiter.md
Name: wb_write_port_arbiter

Overview:
- Shares the single register-file write port between the two write-back lanes (inst0, inst1) of the dual-issue pipeline.
- Sits after both MEM/WB pipeline registers and in front of the register file.
- Same-cycle lane conflicts are resolved in program order: inst0 is older than inst1.
- Writes that cannot be served immediately are held in a small in-order pending queue. A lookup port lets decode/forwarding find values that have not yet been written.

Parameters:
- DEPTH, 4, pending-queue entries (>=2)
- ADDR_W, 5, register address width
- DATA_W, 32, write-data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- RegWriteEn_inst0_WB  in  1  lane0 write request
- dest_reg_inst0_WB  in  ADDR_W  lane0 destination
- writeData_inst0_WB  in  DATA_W  lane0 data
- RegWriteEn_inst1_WB  in  1  lane1 write request
- dest_reg_inst1_WB  in  ADDR_W  lane1 destination
- writeData_inst1_WB  in  DATA_W  lane1 data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- lookup_addr  in  ADDR_W  forwarding query address
- lookup_hit  out  1  query matches a not-yet-committed write (combinational)
- lookup_data  out  DATA_W  newest matching data (combinational)
- wb_stall  out  1  upstream must hold both lanes invalid next cycle (combinational)
- pend_count  out  clog2(DEPTH+1)  queue occupancy
- overflow_err  out  1  sticky error flag

Behaviour:
- Reset: asynchronous, active-high.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Queue emptied, pend_count=0, overflow_err=0.
  - Reset mid-operation discards all pending writes.
- Request qualification: a lane request is valid only when its RegWriteEn=1 and its dest!=0. Writes to x0 are dropped silently.
- Same-destination collapse: both lanes valid with equal dest -> inst0 dropped, only inst1 considered.
- Per-cycle selection (one write per cycle):
  - Queue non-empty: the output stage loads the queue head, which is popped. All valid lane requests are enqueued in order inst0 then inst1.
  - Queue empty: the output stage loads lane0 if valid, else lane1. The remaining valid lane, if any, is enqueued.
  - Nothing selected: rf_we<=0 next cycle; rf_waddr and rf_wdata hold their values.
- Latency:
  - With the queue empty, the lane0 write appears on rf_* one cycle after it is presented.
  - A queued entry appears one cycle after it reaches the head.
- Queue behaviour:
  - Circular FIFO; read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle are legal.
  - Net growth is at most +1 per cycle.
- Flow control:
  - wb_stall = (pend_count >= DEPTH-1).
  - The upstream pipeline freezes MEM/WB while wb_stall=1. Lane inputs must be held invalid in that case.
- Overflow: any enqueue when the queue is full (after that cycle's pop) is dropped and sets overflow_err=1. overflow_err is sticky until reset.
- Lookup, priority newest-first:
  1. queue entries, tail toward head;
  2. the output stage when rf_we=1.
  - lookup_addr=0 -> lookup_hit=0.
  - No match -> lookup_hit=0, lookup_data=0.
  - Current-cycle lane inputs are NOT searched; the existing EX/MEM forwarding covers them.
- Ordering guarantee: writes reach the register file in program order. Later writes to a register always commit after earlier ones.

Test Plan:
- Reset, then lane0 only (dest=5, data=0xAA) -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; pend_count stays 0.
- Both lanes, dest 3/0x11 and dest 4/0x22, queue empty -> cycle+1 writes r3=0x11; cycle+2 writes r4=0x22; pend_count goes 1 then 0.
- Both lanes with dest=7 (0x01 and 0x02) -> only r7=0x02 written, once; lookup_addr=7 returns hit, 0x02, while in the output stage.
- Dual writes to distinct registers on consecutive cycles (DEPTH=4):
  - wb_stall asserts when pend_count reaches 3.
  - After the inputs are idled, the queue drains in program order and overflow_err stays 0.
- Violate the stall by driving dual writes for 5 cycles -> overflow_err=1 and stays 1 until reset. Asserting reset mid-drain -> rf_we=0 and pend_count=0 immediately.
- Lane writes to dest=0 with RegWriteEn=1 -> no rf_we and no enqueue. lookup_addr=0 -> lookup_hit=0.
